// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-outstanding memory unit.
// Port A (instruction fetch) and port B (data) compete for one request
// slot. Contention is resolved round-robin or with fixed A priority.
// Every output is a flop, so there is no combinational input-to-output path.
module mem_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        a_req,
  input  logic [15:0] a_addr,
  input  logic        a_rwn,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic [15:0] b_addr,
  input  logic        b_rwn,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        b_rvalid,
  output logic [15:0] m_memaddr,
  output logic        m_enable,
  output logic        m_rwn,
  output logic [15:0] m_data_in,
  input  logic        m_ready,
  input  logic [15:0] m_data_out,
  input  logic        m_data_valid
);

  localparam bit RR = (ROUND_ROBIN != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        started_q, started_d;   // set one edge after reset release
  logic        last_b_q, last_b_d;     // 1 = port B was served last
  logic        gnt_b_q, gnt_b_d;       // port owning the current transaction
  logic        rd_pend_q, rd_pend_d;   // granted read still awaiting its data
  logic [15:0] m_memaddr_q, m_memaddr_d;
  logic        m_enable_q, m_enable_d;
  logic        m_rwn_q, m_rwn_d;
  logic [15:0] m_data_in_q, m_data_in_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        a_rvalid_q, a_rvalid_d;
  logic        b_rvalid_q, b_rvalid_d;
  logic        pick_a;

  // Next-state logic: arbitration in IDLE, handshake tracking afterwards,
  // and read-data capture whenever a read is in flight.
  always_comb begin
    state_d     = state_q;
    started_d   = 1'b1;
    last_b_d    = last_b_q;
    gnt_b_d     = gnt_b_q;
    rd_pend_d   = rd_pend_q;
    m_memaddr_d = m_memaddr_q;
    m_enable_d  = m_enable_q;
    m_rwn_d     = m_rwn_q;
    m_data_in_d = m_data_in_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;

    // A wins when alone, under fixed priority, or when B was served last.
    pick_a = a_req && (!b_req || !RR || last_b_q);

    case (state_q)
      IDLE: begin
        // started_q delays the first grant to the second edge after reset.
        if (started_q && m_ready && (a_req || b_req)) begin
          if (pick_a) begin
            m_memaddr_d = a_addr;
            m_rwn_d     = a_rwn;
            m_data_in_d = a_wdata;
            gnt_b_d     = 1'b0;
            rd_pend_d   = a_rwn;
            a_ack_d     = 1'b1;
          end else begin
            m_memaddr_d = b_addr;
            m_rwn_d     = b_rwn;
            m_data_in_d = b_wdata;
            gnt_b_d     = 1'b1;
            rd_pend_d   = b_rwn;
            b_ack_d     = 1'b1;
          end
          m_enable_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // The memory drops m_ready once it has taken the request.
        if (!m_ready) begin
          m_enable_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Back to IDLE without granting on this edge: IDLE lasts >= 1 cycle.
        if (m_ready) begin
          last_b_d  = gnt_b_q;
          rd_pend_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is only accepted for a granted read that is still pending,
    // which also filters out stray m_data_valid in IDLE and on writes.
    if (state_q != IDLE && rd_pend_q && m_data_valid) begin
      rd_pend_d = 1'b0;
      if (gnt_b_q) begin
        b_rdata_d  = m_data_out;
        b_rvalid_d = 1'b1;
      end else begin
        a_rdata_d  = m_data_out;
        a_rvalid_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      started_q   <= 1'b0;
      last_b_q    <= 1'b1;
      gnt_b_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      m_memaddr_q <= 16'h0000;
      m_enable_q  <= 1'b0;
      m_rwn_q     <= 1'b1;
      m_data_in_q <= 16'h0000;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= 16'h0000;
      b_rdata_q   <= 16'h0000;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      last_b_q    <= last_b_d;
      gnt_b_q     <= gnt_b_d;
      rd_pend_q   <= rd_pend_d;
      m_memaddr_q <= m_memaddr_d;
      m_enable_q  <= m_enable_d;
      m_rwn_q     <= m_rwn_d;
      m_data_in_q <= m_data_in_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
    end
  end

  assign m_memaddr = m_memaddr_q;
  assign m_enable  = m_enable_q;
  assign m_rwn     = m_rwn_q;
  assign m_data_in = m_data_in_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin, instance 1 is fixed
// A-priority. Each instance has its own behavioural memory unit. A
// transaction-level model (grant rule, reference memory, expected rdata)
// predicts the results.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst = 1'b0;
  logic        a_req [2] = '{1'b0, 1'b0};
  logic        b_req [2] = '{1'b0, 1'b0};
  logic        a_rwn [2] = '{1'b1, 1'b1};
  logic        b_rwn [2] = '{1'b1, 1'b1};
  logic [15:0] a_addr [2] = '{16'h0, 16'h0};
  logic [15:0] b_addr [2] = '{16'h0, 16'h0};
  logic [15:0] a_wdata [2] = '{16'h0, 16'h0};
  logic [15:0] b_wdata [2] = '{16'h0, 16'h0};
  logic        a_ack [2], b_ack [2], a_rvalid [2], b_rvalid [2];
  logic [15:0] a_rdata [2], b_rdata [2], m_memaddr [2], m_data_in [2];
  logic        m_enable [2], m_rwn [2];
  logic        m_ready [2] = '{1'b1, 1'b1};
  logic        m_data_valid [2] = '{1'b0, 1'b0};
  logic [15:0] m_data_out [2] = '{16'h0, 16'h0};

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .nrst(nrst),
    .a_req(a_req[0]), .a_addr(a_addr[0]), .a_rwn(a_rwn[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
    .b_req(b_req[0]), .b_addr(b_addr[0]), .b_rwn(b_rwn[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
    .m_memaddr(m_memaddr[0]), .m_enable(m_enable[0]), .m_rwn(m_rwn[0]),
    .m_data_in(m_data_in[0]), .m_ready(m_ready[0]), .m_data_out(m_data_out[0]),
    .m_data_valid(m_data_valid[0])
  );

  mem_arbiter #(.ROUND_ROBIN(0)) u_fx (
    .clk(clk), .nrst(nrst),
    .a_req(a_req[1]), .a_addr(a_addr[1]), .a_rwn(a_rwn[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
    .b_req(b_req[1]), .b_addr(b_addr[1]), .b_rwn(b_rwn[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
    .m_memaddr(m_memaddr[1]), .m_enable(m_enable[1]), .m_rwn(m_rwn[1]),
    .m_data_in(m_data_in[1]), .m_ready(m_ready[1]), .m_data_out(m_data_out[1]),
    .m_data_valid(m_data_valid[1])
  );

  // Initial memory contents; word 0 holds 16'h000B.
  function automatic logic [15:0] init_word(input int a);
    return (a == 0) ? 16'h000B : (16'(a) ^ 16'h5A00);
  endfunction

  // ---------------- behavioural memory units ----------------
  logic [15:0] mem [2][65536];
  bit          mem_init_done = 1'b0;
  bit          busy [2];
  int          busy_cnt [2];
  logic        acc_rwn [2];
  logic [15:0] acc_addr [2];
  logic [15:0] acc_data [2];
  int          done_cnt [2];
  bit          stall [2];
  int          force_lat [2];

  // Accept when idle and enabled, drop m_ready for a few cycles, then
  // answer: read data with m_data_valid alongside m_ready rising.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 65536; a++) mem[i][a] = init_word(a);
      mem_init_done = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      m_data_valid[i] = 1'b0;
      if (busy[i]) begin
        busy_cnt[i]--;
        if (busy_cnt[i] == 0) begin
          busy[i] = 1'b0;
          if (acc_rwn[i]) begin
            m_data_out[i]   = mem[i][acc_addr[i]];
            m_data_valid[i] = 1'b1;
          end else begin
            mem[i][acc_addr[i]] = acc_data[i];
          end
          m_ready[i] = 1'b1;
          done_cnt[i]++;
        end
      end else if (stall[i]) begin
        m_ready[i] = 1'b0;
      end else if (m_ready[i] && m_enable[i] === 1'b1) begin
        acc_rwn[i]  = m_rwn[i];
        acc_addr[i] = m_memaddr[i];
        acc_data[i] = m_data_in[i];
        m_ready[i]  = 1'b0;
        busy_cnt[i] = (force_lat[i] != 0) ? force_lat[i] : int'($urandom_range(1, 4));
        busy[i]     = 1'b1;
      end else begin
        m_ready[i] = 1'b1;
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [15:0] ref_mem [2][65536];
  logic [15:0] exp_rd [2][2];   // [instance][0=A,1=B]
  int          last_port [2];   // 0 = A served last, 1 = B served last

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input int i, input string s);
    return $sformatf("u%0d.%s", i, s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(tg(i, "rst_m_enable"), 32'(m_enable[i]), 32'd0);
      chk(tg(i, "rst_m_memaddr"), 32'(m_memaddr[i]), 32'd0);
      chk(tg(i, "rst_m_rwn"), 32'(m_rwn[i]), 32'd1);
      chk(tg(i, "rst_m_data_in"), 32'(m_data_in[i]), 32'd0);
      chk(tg(i, "rst_a_ack"), 32'(a_ack[i]), 32'd0);
      chk(tg(i, "rst_b_ack"), 32'(b_ack[i]), 32'd0);
      chk(tg(i, "rst_a_rvalid"), 32'(a_rvalid[i]), 32'd0);
      chk(tg(i, "rst_b_rvalid"), 32'(b_rvalid[i]), 32'd0);
      chk(tg(i, "rst_a_rdata"), 32'(a_rdata[i]), 32'd0);
      chk(tg(i, "rst_b_rdata"), 32'(b_rdata[i]), 32'd0);
      last_port[i] = 1;
      exp_rd[i][0] = 16'h0;
      exp_rd[i][1] = 16'h0;
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // One arbitrated transaction on instance i. The model picks the winner,
  // then the bench checks the grant, the memory-side request, the rvalid
  // count over the whole transaction and both ports' rdata.
  task automatic do_round(input int i, input bit ra, input bit rb,
                          input logic [15:0] aa, input logic arw, input logic [15:0] awd,
                          input logic [15:0] ba, input logic brw, input logic [15:0] bwd,
                          input bit hold);
    bit          win_b, got;
    int          dc0, rva, rvb, acks;
    logic [15:0] ex_addr, ex_wd;
    logic        ex_rw;
    if (ra && rb) win_b = (i == 0) ? (last_port[i] == 0) : 1'b0;
    else          win_b = rb;
    ex_addr = win_b ? ba  : aa;
    ex_rw   = win_b ? brw : arw;
    ex_wd   = win_b ? bwd : awd;

    @(negedge clk);
    a_req[i] = ra; a_addr[i] = aa; a_rwn[i] = arw; a_wdata[i] = awd;
    b_req[i] = rb; b_addr[i] = ba; b_rwn[i] = brw; b_wdata[i] = bwd;

    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      got = (a_ack[i] === 1'b1) || (b_ack[i] === 1'b1);
      if (got) break;
    end
    chk(tg(i, "ack_seen"), 32'(got), 32'd1);
    if (!got) return;
    chk(tg(i, "a_ack"), 32'(a_ack[i]), 32'(!win_b));
    chk(tg(i, "b_ack"), 32'(b_ack[i]), 32'(win_b));
    chk(tg(i, "m_memaddr"), 32'(m_memaddr[i]), 32'(ex_addr));
    chk(tg(i, "m_rwn"), 32'(m_rwn[i]), 32'(ex_rw));
    chk(tg(i, "m_data_in"), 32'(m_data_in[i]), 32'(ex_wd));
    chk(tg(i, "m_enable_on"), 32'(m_enable[i]), 32'd1);
    dc0 = done_cnt[i];
    if (!hold) begin
      @(negedge clk);
      a_req[i] = 1'b0;
      b_req[i] = 1'b0;
    end

    rva = 0; rvb = 0; acks = 0; got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (a_rvalid[i] === 1'b1) rva++;
      if (b_rvalid[i] === 1'b1) rvb++;
      if (a_ack[i] === 1'b1 || b_ack[i] === 1'b1) acks++;
      got = (done_cnt[i] != dc0);
      if (got) break;
    end
    chk(tg(i, "completed"), 32'(got), 32'd1);

    if (ex_rw) exp_rd[i][win_b] = ref_mem[i][ex_addr];
    else       ref_mem[i][ex_addr] = ex_wd;
    last_port[i] = win_b ? 1 : 0;

    chk(tg(i, "a_rvalid_cnt"), 32'(rva), (ex_rw && !win_b) ? 32'd1 : 32'd0);
    chk(tg(i, "b_rvalid_cnt"), 32'(rvb), (ex_rw && win_b) ? 32'd1 : 32'd0);
    chk(tg(i, "acks_in_flight"), 32'(acks), 32'd0);
    chk(tg(i, "a_rdata"), 32'(a_rdata[i]), 32'(exp_rd[i][0]));
    chk(tg(i, "b_rdata"), 32'(b_rdata[i]), 32'(exp_rd[i][1]));
    chk(tg(i, "m_memaddr_held"), 32'(m_memaddr[i]), 32'(ex_addr));
    chk(tg(i, "m_enable_off"), 32'(m_enable[i]), 32'd0);
    $display("txn u%0d port=%s %s addr=%04h data=%04h", i, win_b ? "B" : "A",
             ex_rw ? "RD" : "WR", ex_addr, ex_rw ? exp_rd[i][win_b] : ex_wd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit          got;
    int          rv;
    bit          ra, rb;

    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 65536; a++) ref_mem[i][a] = init_word(a);
      last_port[i] = 1;
      force_lat[i] = 0;
      stall[i]     = 1'b0;
    end

    // Request held through reset: no grant on the first edge after release.
    a_req[0] = 1'b1; a_addr[0] = 16'h0000; a_rwn[0] = 1'b1;
    do_reset();
    tick();
    chk("u0.first_edge_no_ack", 32'(a_ack[0]), 32'd0);

    // Single read of word 0 on A.
    do_round(0, 1, 0, 16'h0000, 1'b1, 16'h0, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("u0.read0_value", 32'(a_rdata[0]), 32'h000B);

    // Write on B, then read it back on B.
    do_round(0, 0, 1, 16'h0, 1'b1, 16'h0, 16'h0010, 1'b0, 16'h1234, 1'b0);
    do_round(0, 0, 1, 16'h0, 1'b1, 16'h0, 16'h0010, 1'b1, 16'h0000, 1'b0);
    chk("u0.readback_value", 32'(b_rdata[0]), 32'h1234);

    // Round-robin contention, both requests held: A,B,A,B.
    do_reset();
    for (int k = 0; k < 4; k++)
      do_round(0, 1, 1, 16'(8 + k), 1'b1, 16'h0, 16'(12 + k), 1'b1, 16'h0, 1'b1);
    @(negedge clk);
    a_req[0] = 1'b0; b_req[0] = 1'b0;

    // Fixed priority contention: A every time.
    do_reset();
    for (int k = 0; k < 3; k++)
      do_round(1, 1, 1, 16'(20 + k), 1'b1, 16'h0, 16'(24 + k), 1'b1, 16'h0, 1'b1);
    @(negedge clk);
    a_req[1] = 1'b0; b_req[1] = 1'b0;

    // Reset while a read is waiting for the memory.
    force_lat[0] = 6;
    @(negedge clk);
    a_req[0] = 1'b1; a_addr[0] = 16'h0003; a_rwn[0] = 1'b1; b_req[0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      got = (a_ack[0] === 1'b1);
      if (got) break;
    end
    chk("u0.midrst_ack", 32'(got), 32'd1);
    @(negedge clk);
    a_req[0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      got = (m_enable[0] === 1'b0);
      if (got) break;
    end
    chk("u0.midrst_in_wait", 32'(got), 32'd1);
    do_reset();
    rv = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (a_rvalid[0] === 1'b1 || b_rvalid[0] === 1'b1) rv++;
    end
    chk("u0.midrst_no_rvalid", 32'(rv), 32'd0);
    chk("u0.midrst_rdata", 32'(a_rdata[0]), 32'd0);
    force_lat[0] = 0;
    do_round(0, 1, 0, 16'h0003, 1'b1, 16'h0, 16'h0, 1'b1, 16'h0, 1'b0);

    // Stalled memory: m_ready low, request must sit ungranted.
    tick();
    stall[0] = 1'b1;
    @(negedge clk);
    a_req[0] = 1'b1; a_addr[0] = 16'h0005; a_rwn[0] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (a_ack[0] !== 1'b0 || m_enable[0] !== 1'b0 || b_ack[0] !== 1'b0) got = 1'b1;
    end
    chk("u0.stall_no_grant", 32'(got), 32'd0);
    chk("u0.stall_m_enable", 32'(m_enable[0]), 32'd0);
    @(negedge clk);
    a_req[0] = 1'b0;
    stall[0] = 1'b0;

    // Randomised traffic on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 12; k++) begin
        ra = 1'($urandom_range(0, 1));
        rb = 1'($urandom_range(0, 1));
        if (!ra && !rb) ra = 1'b1;
        do_round(i, ra, rb,
                 16'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                 16'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                 1'b0);
      end
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = alternate grants on contention and 0 = port A always wins.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port nrst, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have ports a_req/b_req, input, 1 each, request from port A (instruction fetch) and port B (data).
REQ-005 SHALL have ports a_addr/b_addr, input, 16, word address.
REQ-006 SHALL have ports a_rwn/b_rwn, input, 1, 1 = read and 0 = write.
REQ-007 SHALL have ports a_wdata/b_wdata, input, 16, write data.
REQ-008 SHALL have ports a_ack/b_ack, output, 1, one-cycle request-accepted pulse.
REQ-009 SHALL have ports a_rdata/b_rdata, output, 16, read data, held until the next read on that port.
REQ-010 SHALL have ports a_rvalid/b_rvalid, output, 1, one-cycle read-data-valid pulse.
REQ-011 SHALL have ports m_memaddr, output, 16; m_enable, output, 1; m_rwn, output, 1; m_data_in, output, 16, which drive the memunit request side.
REQ-012 SHALL have ports m_ready, input, 1; m_data_out, input, 16; m_data_valid, input, 1, which come from the memunit response side.

Function
REQ-013 SHALL register all outputs, with no combinational path from input to output.
REQ-014 SHALL implement FSM states IDLE, ISSUE and WAIT_DONE.
REQ-015 SHALL, in IDLE with m_ready=1 and at least one req high, on the next edge: latch the winner's addr, rwn and wdata into m_memaddr, m_rwn and m_data_in; pulse the winner's ack for 1 cycle; set m_enable=1; enter ISSUE.
REQ-016 SHALL, in IDLE with m_ready=0, grant nothing and leave all acks at 0.
REQ-017 SHALL, when both ports request with ROUND_ROBIN=1, grant the port not served last; last-served is B after reset, so A wins first contention.
REQ-018 SHALL, when both ports request with ROUND_ROBIN=0, grant A.
REQ-019 SHALL, in ISSUE, hold m_enable=1 until m_ready=0 is sampled, then clear m_enable on that edge and enter WAIT_DONE.
REQ-020 SHALL, on m_data_valid=1 in ISSUE or WAIT_DONE for a granted read, copy m_data_out into the granted port's rdata and pulse its rvalid for exactly 1 cycle.
REQ-021 SHALL NOT change rdata or pulse rvalid on any port for a write.
REQ-022 SHALL, in WAIT_DONE with m_ready=1 sampled, record last-served, return to IDLE and start no new grant on that same edge; the minimum IDLE dwell is 1 cycle.
REQ-023 SHALL ignore m_data_valid while in IDLE.
REQ-024 SHALL, if a requester keeps req high after ack, treat it as a new request, subject to arbitration.
REQ-025 SHALL keep m_memaddr, m_rwn and m_data_in stable from grant until return to IDLE.
REQ-026 SHALL have exactly one transaction outstanding at any time.

Reset
REQ-027 SHALL, on nrst=0 asynchronously: enter IDLE; set m_enable=0, m_memaddr=0, m_rwn=1, m_data_in=0, a_ack=b_ack=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, last-served=B.
REQ-028 SHALL, on reset mid-transaction, abandon the transaction, emit no rvalid and re-grant nothing until m_ready=1 is seen in IDLE.
REQ-029 SHALL make its first grant no earlier than the second edge after nrst deasserts.

Verification
REQ-030 SHALL cover a single read: memory word 0 = 16'h000B; a_req, a_addr=0, a_rwn=1 after m_ready -> a_ack 1 cycle, m_enable until m_ready falls, a_rvalid 1 cycle with a_rdata=16'h000B, b_rvalid stays 0.
REQ-031 SHALL cover a write then read-back: b_req, b_addr=16'h0010, b_rwn=0, b_wdata=16'h1234 -> no b_rvalid; then a read of 16'h0010 on B -> b_rdata=16'h1234.
REQ-032 SHALL cover contention with ROUND_ROBIN=1: a_req and b_req held high for 4 transactions -> grant order A,B,A,B, each ack seen only after the previous m_ready return.
REQ-033 SHALL cover contention with ROUND_ROBIN=0: both held high for 3 transactions -> all grants to A, b_ack never asserts.
REQ-034 SHALL cover reset mid-read: nrst pulsed low during WAIT_DONE -> all outputs at reset values immediately, no rvalid, a new request is served correctly after m_ready rises.
REQ-035 SHALL cover a stalled memory: m_ready held 0 with a_req high for 20 cycles -> a_ack and m_enable stay 0.
